// File: rtl/transition_counter_pkg.sv
// Shared definitions for the multi-channel transition counter:
// edge-mode encodings and the polarity-select helper used by each channel.
package transition_counter_pkg;

  typedef enum logic [1:0] {
    EM_OFF  = 2'b00,
    EM_RISE = 2'b01,
    EM_FALL = 2'b10,
    EM_BOTH = 2'b11
  } edge_mode_e;

  // Bit 0 of the mode enables rising edges, bit 1 enables falling edges.
  function automatic logic edgeHit(input logic [1:0] mode, input logic rise, input logic fall);
    logic riseEn;
    logic fallEn;
    riseEn = ((mode & EM_RISE) == EM_RISE);
    fallEn = ((mode & EM_FALL) == EM_FALL);
    return (riseEn & rise) | (fallEn & fall);
  endfunction

endpackage

// File: rtl/edge_counter_channel.sv
// One monitored channel: input synchroniser, priming, edge detection and a
// WIDTH-bit wrapping or saturating counter with a sticky overflow flag.
module edge_counter_channel
  import transition_counter_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int SATURATE    = 0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_i,
  input  logic [1:0]       edgeMode_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o,
  output logic             ovf_o
);

  localparam logic [WIDTH-1:0] COUNT_MAX = '1;
  localparam logic [WIDTH-1:0] COUNT_ONE = WIDTH'(1);

  logic             syncOut;
  logic             syncValid;
  logic             prev_q;
  logic             primed_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             rise;
  logic             fall;
  logic             hit;

  if (SYNC_STAGES == 0) begin : gNoSync
    assign syncOut   = in_i;
    assign syncValid = 1'b1;
  end else begin : gSync
    logic [SYNC_STAGES-1:0] syncChain_q;
    logic [SYNC_STAGES-1:0] fill_q;

    // Synchroniser chain plus a matching fill marker; the reset value of the
    // chain does not reflect the pin, so priming waits until the chain has refilled.
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        syncChain_q <= '0;
        fill_q      <= '0;
      end else begin
        syncChain_q[0] <= in_i;
        fill_q[0]      <= 1'b1;
        for (int k = 1; k < SYNC_STAGES; k++) begin
          syncChain_q[k] <= syncChain_q[k-1];
          fill_q[k]      <= fill_q[k-1];
        end
      end
    end

    assign syncOut   = syncChain_q[SYNC_STAGES-1];
    assign syncValid = fill_q[SYNC_STAGES-1];
  end

  // Edge detection and next count; clear beats a simultaneous hit.
  always_comb begin
    rise    = syncOut & ~prev_q;
    fall    = ~syncOut & prev_q;
    hit     = primed_q & edgeHit(edgeMode_i, rise, fall);
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr_i) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (hit) begin
      if (count_q == COUNT_MAX) begin
        ovf_d   = 1'b1;
        count_d = (SATURATE != 0) ? COUNT_MAX : '0;
      end else begin
        count_d = count_q + COUNT_ONE;
      end
    end
  end

  // Prime on the first valid synchronised sample, then track prev every cycle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      prev_q   <= 1'b0;
      primed_q <= 1'b0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (syncValid) begin
        prev_q   <= syncOut;
        primed_q <= 1'b1;
      end
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o = count_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/multi_transition_counter.sv
// N-channel transition counter: one edge_counter_channel per input, a
// registered read port selected by rd_sel, and a registered overflow summary.
module multi_transition_counter
  import transition_counter_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int SATURATE    = 0,
  localparam int SEL_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  in,
  input  logic [1:0]       edge_mode,
  input  logic [N_CH-1:0]  clr,
  input  logic [SEL_W-1:0] rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_ovf,
  output logic             ovf_any
);

  logic [WIDTH-1:0] chCount [N_CH];
  logic [N_CH-1:0]  chOvf;
  logic [WIDTH-1:0] rdData_d;
  logic [WIDTH-1:0] rdData_q;
  logic             rdOvf_d;
  logic             rdOvf_q;
  logic             ovfAny_q;
  logic [31:0]      selExt;

  for (genvar i = 0; i < N_CH; i++) begin : gChan
    edge_counter_channel #(
      .WIDTH      (WIDTH),
      .SYNC_STAGES(SYNC_STAGES),
      .SATURATE   (SATURATE)
    ) uChan (
      .clk_i     (clk),
      .reset_i   (reset),
      .in_i      (in[i]),
      .edgeMode_i(edge_mode),
      .clr_i     (clr[i]),
      .count_o   (chCount[i]),
      .ovf_o     (chOvf[i])
    );
  end

  assign selExt = {{(32-SEL_W){1'b0}}, rd_sel};

  // Read mux; a select beyond the last channel reads as zero.
  always_comb begin
    rdData_d = '0;
    rdOvf_d  = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (selExt == 32'(i)) begin
        rdData_d = chCount[i];
        rdOvf_d  = chOvf[i];
      end
    end
  end

  // Registered read port and overflow summary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdData_q <= '0;
      rdOvf_q  <= 1'b0;
      ovfAny_q <= 1'b0;
    end else begin
      rdData_q <= rdData_d;
      rdOvf_q  <= rdOvf_d;
      ovfAny_q <= |chOvf;
    end
  end

  assign rd_data = rdData_q;
  assign rd_ovf  = rdOvf_q;
  assign ovf_any = ovfAny_q;

endmodule

// File: tb/tb_multi_transition_counter.sv
// Directed bench for multi_transition_counter. Two instances share all
// inputs: one wraps (SATURATE=0), one saturates (SATURATE=1).
module tb_multi_transition_counter;
  import transition_counter_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] sigIn = 4'b1111;
  logic [1:0] edgeMode = EM_BOTH;
  logic [3:0] clr = 4'b0000;
  logic [1:0] rdSel = 2'd0;

  logic [3:0] rdData0, rdData1;
  logic       rdOvf0, rdOvf1;
  logic       ovfAny0, ovfAny1;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    int         ch;
    logic [3:0] data0;
    logic       ovf0;
    logic [3:0] data1;
    logic       ovf1;
  } readExp_t;

  readExp_t expQ[$];
  string    tagQ[$];

  multi_transition_counter #(
    .N_CH(4), .WIDTH(4), .SYNC_STAGES(2), .SATURATE(0)
  ) dutWrap (
    .clk(clk), .reset(reset), .in(sigIn), .edge_mode(edgeMode), .clr(clr),
    .rd_sel(rdSel), .rd_data(rdData0), .rd_ovf(rdOvf0), .ovf_any(ovfAny0)
  );

  multi_transition_counter #(
    .N_CH(4), .WIDTH(4), .SYNC_STAGES(2), .SATURATE(1)
  ) dutSat (
    .clk(clk), .reset(reset), .in(sigIn), .edge_mode(edgeMode), .clr(clr),
    .rd_sel(rdSel), .rd_data(rdData1), .rd_ovf(rdOvf1), .ovf_any(ovfAny1)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Toggle one channel n times, spaced three cycles apart, then let it settle.
  task automatic applyStimulus(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sigIn[ch] = ~sigIn[ch];
      repeat (2) @(negedge clk);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic expectRead(input string tag, input int ch,
                            input logic [3:0] d0, input logic o0,
                            input logic [3:0] d1, input logic o1);
    readExp_t e;
    e.ch = ch; e.data0 = d0; e.ovf0 = o0; e.data1 = d1; e.ovf1 = o1;
    expQ.push_back(e);
    tagQ.push_back(tag);
  endtask

  // Drain the scoreboard: select each channel and compare the registered read.
  task automatic checkOutput();
    while (expQ.size() > 0) begin
      readExp_t e;
      string    t;
      e = expQ.pop_front();
      t = tagQ.pop_front();
      @(negedge clk);
      rdSel = 2'(e.ch);
      @(posedge clk);
      #1;
      checkVal({t, "/data_wrap"}, 16'(rdData0), 16'(e.data0));
      checkVal({t, "/ovf_wrap"},  16'(rdOvf0),  16'(e.ovf0));
      checkVal({t, "/data_sat"},  16'(rdData1), 16'(e.data1));
      checkVal({t, "/ovf_sat"},   16'(rdOvf1),  16'(e.ovf1));
    end
  endtask

  initial begin
    // Reset with all inputs high and both-edge mode.
    reset = 1'b1;
    sigIn = 4'b1111;
    edgeMode = EM_BOTH;
    repeat (3) @(negedge clk);
    checkVal("reset/rd_data", 16'(rdData0), 16'd0);
    checkVal("reset/ovf_any", 16'(ovfAny0), 16'd0);
    reset = 1'b0;

    // Levels held through release must not count.
    repeat (10) @(negedge clk);
    for (int ch = 0; ch < 4; ch++)
      expectRead($sformatf("prime/ch%0d", ch), ch, 4'd0, 1'b0, 4'd0, 1'b0);
    checkOutput();
    checkVal("prime/ovf_any_wrap", 16'(ovfAny0), 16'd0);
    checkVal("prime/ovf_any_sat",  16'(ovfAny1), 16'd0);

    // Latency: rising-only mode, ch0 falls first (ignored) then rises.
    @(negedge clk);
    edgeMode = EM_RISE;
    sigIn[0] = 1'b0;
    rdSel = 2'd0;
    repeat (5) @(negedge clk);
    sigIn[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkVal("latency/k+2", 16'(rdData0), 16'd0);
    @(posedge clk);
    #1;
    checkVal("latency/k+3_wrap", 16'(rdData0), 16'd1);
    checkVal("latency/k+3_sat",  16'(rdData1), 16'd1);

    // Polarity: falling-only gives 5, then both edges adds 10.
    @(negedge clk);
    edgeMode = EM_FALL;
    applyStimulus(1, 10);
    expectRead("polarity/fall", 1, 4'd5, 1'b0, 4'd5, 1'b0);
    checkOutput();
    edgeMode = EM_BOTH;
    applyStimulus(1, 10);
    expectRead("polarity/both", 1, 4'd15, 1'b0, 4'd15, 1'b0);
    checkOutput();

    // Overflow: 17 hits on ch2 wraps to 1 or holds at 15, flag set either way.
    applyStimulus(2, 17);
    expectRead("overflow/ch2", 2, 4'd1, 1'b1, 4'd15, 1'b1);
    checkOutput();
    checkVal("overflow/ovf_any_wrap", 16'(ovfAny0), 16'd1);
    checkVal("overflow/ovf_any_sat",  16'(ovfAny1), 16'd1);

    // Clear colliding with a hit on ch3: clear wins and the edge is lost.
    applyStimulus(3, 7);
    expectRead("clear/pre", 3, 4'd7, 1'b0, 4'd7, 1'b0);
    checkOutput();
    @(negedge clk);
    sigIn[3] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clr = 4'b1000;
    @(negedge clk);
    clr = 4'b0000;
    repeat (4) @(negedge clk);
    expectRead("clear/collide", 3, 4'd0, 1'b0, 4'd0, 1'b0);
    checkOutput();

    // Clearing ch2 drops its sticky flag and the summary.
    @(negedge clk);
    clr = 4'b0100;
    @(negedge clk);
    clr = 4'b0000;
    expectRead("clear/ch2", 2, 4'd0, 1'b0, 4'd0, 1'b0);
    checkOutput();
    checkVal("clear/ovf_any_wrap", 16'(ovfAny0), 16'd0);
    checkVal("clear/ovf_any_sat",  16'(ovfAny1), 16'd0);
    applyStimulus(3, 1);
    expectRead("clear/next_hit", 3, 4'd1, 1'b0, 4'd1, 1'b0);
    checkOutput();

    // One more hit on ch1 at max: wrap to 0 or hold at 15.
    applyStimulus(1, 1);
    expectRead("wrap/ch1", 1, 4'd0, 1'b1, 4'd15, 1'b1);
    checkOutput();
    checkVal("wrap/ovf_any_wrap", 16'(ovfAny0), 16'd1);

    // Async reset between clock edges while ch0 toggles.
    @(posedge clk);
    #3;
    sigIn[0] = ~sigIn[0];
    #1;
    reset = 1'b1;
    #1;
    checkVal("areset/rd_data_sat", 16'(rdData1), 16'd0);
    checkVal("areset/rd_ovf_wrap", 16'(rdOvf0),  16'd0);
    checkVal("areset/ovf_any_wrap", 16'(ovfAny0), 16'd0);
    checkVal("areset/ovf_any_sat",  16'(ovfAny1), 16'd0);
    repeat (2) @(negedge clk);
    sigIn[0] = 1'b1;
    rdSel = 2'd0;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    expectRead("rearm/ch0", 0, 4'd0, 1'b0, 4'd0, 1'b0);
    expectRead("rearm/ch1", 1, 4'd0, 1'b0, 4'd0, 1'b0);
    checkOutput();
    applyStimulus(0, 1);
    expectRead("rearm/count", 0, 4'd1, 1'b0, 4'd1, 1'b0);
    checkOutput();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
